// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle load/store core: opcodes,
// sequencer states and instruction field widths.
package cpu_pkg;

    localparam int OP_W   = 4;
    localparam int REG_W  = 3;
    localparam int IMM6_W = 6;
    localparam int IMM9_W = 9;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_AND  = 4'h3;
    localparam logic [OP_W-1:0] OP_OR   = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h7;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h8;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h9;
    localparam logic [OP_W-1:0] OP_LD   = 4'hA;
    localparam logic [OP_W-1:0] OP_ST   = 4'hB;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'hC;
    localparam logic [OP_W-1:0] OP_BNE  = 4'hD;
    localparam logic [OP_W-1:0] OP_JAL  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Opcodes whose result comes out of cpu_alu and is written back to rd.
    function automatic logic isAluOp(input logic [OP_W-1:0] op);
        return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU; ADDI shares the adder, the core supplies sext(imm6) on b.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD, OP_ADDI: y = a + b;
            OP_SUB:          y = a - b;
            OP_AND:          y = a & b;
            OP_OR:           y = a | b;
            OP_XOR:          y = a ^ b;
            OP_SHL:          y = a << b[3:0];
            OP_SHR:          y = a >> b[3:0];
            default:         y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Multicycle core: FETCH -> EXEC -> (MEM) -> FETCH over one shared memory port.
// Reset is synchronous active-low and also gates the bus combinationally.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                NREGS    = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fromMem,
    output logic              we,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] toMem
);

    state_t            state, stateNext;
    logic [DATA_W-1:0] pc, pcNext;
    logic [DATA_W-1:0] ir, irNext;
    logic [DATA_W-1:0] ea, eaNext;
    logic [DATA_W-1:0] regFile [NREGS];

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd, rs, rt;
    logic [DATA_W-1:0] imm6s, imm9s;
    logic [DATA_W-1:0] rdVal, rsVal, rtVal;
    logic [DATA_W-1:0] aluB, aluY;

    logic              wbEn;
    logic [REG_W-1:0]  wbIdx;
    logic [DATA_W-1:0] wbData;

    logic              weInt;
    logic [DATA_W-1:0] addrInt, toMemInt;

    assign op    = ir[15:12];
    assign rd    = ir[11:9];
    assign rs    = ir[8:6];
    assign rt    = ir[5:3];
    assign imm6s = {{(DATA_W-IMM6_W){ir[IMM6_W-1]}}, ir[IMM6_W-1:0]};
    assign imm9s = {{(DATA_W-IMM9_W){ir[IMM9_W-1]}}, ir[IMM9_W-1:0]};

    // r0 is never written, but force the read to zero so it holds regardless.
    assign rdVal = (rd == '0) ? '0 : regFile[rd];
    assign rsVal = (rs == '0) ? '0 : regFile[rs];
    assign rtVal = (rt == '0) ? '0 : regFile[rt];

    assign aluB = (op == OP_ADDI) ? imm6s : rtVal;

    cpu_alu #(.DATA_W(DATA_W)) uAlu (
        .op (op),
        .a  (rsVal),
        .b  (aluB),
        .y  (aluY)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            ea    <= '0;
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            ir    <= irNext;
            ea    <= eaNext;
            if (wbEn && (wbIdx != '0)) regFile[wbIdx] <= wbData;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        irNext    = ir;
        eaNext    = ea;
        wbEn      = 1'b0;
        wbIdx     = rd;
        wbData    = aluY;
        weInt     = 1'b0;
        addrInt   = pc;
        toMemInt  = '0;

        case (state)
            FETCH: begin
                irNext    = fromMem;
                pcNext    = pc + DATA_W'(1);
                stateNext = EXEC;
            end
            EXEC: begin
                stateNext = FETCH;
                if (isAluOp(op)) wbEn = 1'b1;
                case (op)
                    OP_LDI: begin
                        wbEn   = 1'b1;
                        wbData = imm9s;
                    end
                    OP_LD, OP_ST: begin
                        eaNext    = rsVal + imm6s;
                        stateNext = MEM;
                    end
                    OP_BEQ: if (rdVal == rsVal) pcNext = pc + imm6s;
                    OP_BNE: if (rdVal != rsVal) pcNext = pc + imm6s;
                    OP_JAL: begin
                        // Target uses the old rs even when rd == rs.
                        wbEn   = 1'b1;
                        wbData = pc;
                        pcNext = rsVal + imm6s;
                    end
                    OP_HALT: stateNext = HALT;
                    default: ;
                endcase
            end
            MEM: begin
                addrInt   = ea;
                stateNext = FETCH;
                if (op == OP_ST) begin
                    weInt    = 1'b1;
                    toMemInt = rdVal;
                end else begin
                    wbEn   = 1'b1;
                    wbData = fromMem;
                end
            end
            HALT: ;
            default: stateNext = FETCH;
        endcase
    end

    // Reset owns the bus so the program image can be loaded without interference.
    assign we    = rst & weInt;
    assign addr  = rst ? addrInt  : '0;
    assign toMem = rst ? toMemInt : '0;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboarded bench: an instruction-level model predicts every bus cycle,
// a negedge monitor compares the DUT bus against that trace.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fromMem;
    logic        we;
    logic [15:0] addr;
    logic [15:0] toMem;

    always #5 clk = ~clk;

    cpu_core dut (
        .clk     (clk),
        .rst     (rst),
        .fromMem (fromMem),
        .we      (we),
        .addr    (addr),
        .toMem   (toMem)
    );

    logic [15:0] mem [1024];
    logic        tbWe = 1'b0;
    logic [9:0]  tbAddr = '0;
    logic [15:0] tbData = '0;
    logic [15:0] junk = '0;

    always @(posedge clk) begin
        if (tbWe)    mem[tbAddr]     <= tbData;
        else if (we) mem[addr[9:0]]  <= toMem;
    end

    assign fromMem = rst ? mem[addr[9:0]] : junk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] dat;
        bit          care;
    } ent_t;

    ent_t        sbq[$];
    ent_t        monE;
    int          monCyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] img [1024];
    logic [15:0] mdl [1024];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && sbq.size() > 0) begin
            monE = sbq.pop_front();
            chk($sformatf("bus.we@%0d", monCyc), {31'd0, we}, {31'd0, monE.we});
            chk($sformatf("bus.toMem@%0d", monCyc), {16'd0, toMem}, {16'd0, monE.dat});
            if (monE.care) chk($sformatf("bus.addr@%0d", monCyc), {16'd0, addr}, {16'd0, monE.addr});
            monCyc++;
        end
    end

    task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d, input bit c);
        ent_t e;
        e.we = w; e.addr = a; e.dat = d; e.care = c;
        sbq.push_back(e);
    endtask

    // Instruction-set interpreter: one loop iteration per instruction, emitting
    // the bus cycles that instruction must produce.
    task automatic buildTrace(input int ncyc);
        logic [15:0] r [8];
        logic [15:0] pc, ir, a, b, v, i6, i9, t;
        logic [3:0]  op;
        int          rd, rs, rt, n;
        for (int i = 0; i < 8; i++) r[i] = '0;
        for (int i = 0; i < 1024; i++) mdl[i] = img[i];
        pc = '0;
        n  = 0;
        monCyc = 0;
        while (n < ncyc) begin
            push(1'b0, pc, 16'd0, 1'b1); n++;
            if (n >= ncyc) break;
            ir = mdl[pc[9:0]];
            pc = pc + 16'd1;
            op = ir[15:12]; rd = int'(ir[11:9]); rs = int'(ir[8:6]); rt = int'(ir[5:3]);
            i6 = {{10{ir[5]}}, ir[5:0]};
            i9 = {{7{ir[8]}}, ir[8:0]};
            a  = r[rs];
            b  = r[rt];
            if (op == 4'hF) begin
                while (n < ncyc) begin push(1'b0, pc, 16'd0, 1'b1); n++; end
                break;
            end
            push(1'b0, 16'd0, 16'd0, 1'b0); n++;
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                    case (op)
                        4'h1: v = a + b;
                        4'h2: v = a - b;
                        4'h3: v = a & b;
                        4'h4: v = a | b;
                        4'h5: v = a ^ b;
                        4'h6: v = a << b[3:0];
                        4'h7: v = a >> b[3:0];
                        4'h8: v = a + i6;
                        default: v = i9;
                    endcase
                    if (rd != 0) r[rd] = v;
                end
                4'hA, 4'hB: begin
                    t = a + i6;
                    if (n >= ncyc) break;
                    if (op == 4'hB) begin
                        push(1'b1, t, r[rd], 1'b1);
                        mdl[t[9:0]] = r[rd];
                    end else begin
                        push(1'b0, t, 16'd0, 1'b1);
                        if (rd != 0) r[rd] = mdl[t[9:0]];
                    end
                    n++;
                end
                4'hC: if (r[rd] == a) pc = pc + i6;
                4'hD: if (r[rd] != a) pc = pc + i6;
                4'hE: begin
                    t = a + i6;
                    if (rd != 0) r[rd] = pc;
                    pc = t;
                end
                default: ;
            endcase
        end
    endtask

    task automatic clearImg();
        for (int i = 0; i < 1024; i++) img[i] = 16'h0000;
    endtask

    // Entered and left with rst=0: load the image under reset, run ncyc cycles,
    // reset again and compare the resulting memory with the model.
    task automatic runTest(input string nm, input int ncyc);
        int bad;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i < 5) begin
                chk({nm, " rst.we"}, {31'd0, we}, 32'd0);
                chk({nm, " rst.addr"}, {16'd0, addr}, 32'd0);
                chk({nm, " rst.toMem"}, {16'd0, toMem}, 32'd0);
            end
            junk   = 16'($urandom);
            tbWe   = 1'b1;
            tbAddr = 10'(i);
            tbData = img[i];
        end
        @(negedge clk);
        tbWe = 1'b0;
        buildTrace(ncyc);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < ncyc + 50 && sbq.size() > 0; k++) @(posedge clk);
        chk({nm, " drain"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        chk({nm, " rstNow.we"}, {31'd0, we}, 32'd0);
        chk({nm, " rstNow.addr"}, {16'd0, addr}, 32'd0);
        @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== mdl[i]) bad++;
        chk({nm, " memImage"}, 32'(bad), 32'd0);
    endtask

    initial begin
        // ALU: LDI, LDI, ADD, then store r3 to 0x20 so the sum is visible.
        clearImg();
        img[0] = 16'h9205; img[1] = 16'h9403; img[2] = 16'h1650;
        img[3] = 16'hB69D; img[4] = 16'hF000;
        runTest("alu", 16);
        chk("alu r3", {16'd0, mem[10'h020]}, 32'h0008);

        clearImg();
        img[0] = 16'h92AB; img[1] = 16'h9464; img[2] = 16'hB280; img[3] = 16'hF000;
        runTest("store", 16);
        chk("store mem64", {16'd0, mem[10'h064]}, 32'h00AB);

        clearImg();
        img[0] = 16'h9464; img[1] = 16'hA880; img[2] = 16'hB881; img[3] = 16'hF000;
        img[10'h064] = 16'h1234;
        runTest("load", 20);
        chk("load r4", {16'd0, mem[10'h065]}, 32'h1234);

        clearImg();
        img[5] = 16'hC03F;
        runTest("beqLoop", 40);

        clearImg();
        img[2] = 16'hEE0A; img[10] = 16'h9440; img[11] = 16'hBE80; img[12] = 16'hF000;
        runTest("jal", 30);
        chk("jal r7", {16'd0, mem[10'h040]}, 32'h0003);

        // ADDI -1, SHL by 15, two r0 writes, then store r1/r3/r0.
        clearImg();
        img[0] = 16'h823F; img[1] = 16'h940F; img[2] = 16'h6650; img[3] = 16'h9005;
        img[4] = 16'h1048; img[5] = 16'h9A50; img[6] = 16'hB340; img[7] = 16'hB741;
        img[8] = 16'hB142; img[9] = 16'hF000;
        runTest("edge", 40);
        chk("edge addi", {16'd0, mem[10'h050]}, 32'hFFFF);
        chk("edge shl15", {16'd0, mem[10'h051]}, 32'h8000);
        chk("edge r0", {16'd0, mem[10'h052]}, 32'h0000);

        // Reset lands on the ST MEM cycle: no write may happen.
        clearImg();
        img[0] = 16'h92AB; img[1] = 16'h9464; img[2] = 16'hB280; img[3] = 16'hF000;
        img[10'h064] = 16'h5555;
        runTest("rstMidSt", 6);
        chk("rstMidSt mem64", {16'd0, mem[10'h064]}, 32'h5555);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 1024; i++) img[i] = 16'($urandom);
            runTest($sformatf("rand%0d", t), 300);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
